// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_univ
// Purpose  : Universal shift register with load/shift/rotate/clear and a
//            burst FSM that repeats one shift mode a programmed number of times.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_univ #(
    parameter int          WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int          CNT_W   = $clog2(WIDTH) + 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] C_M_HOLD = 3'd0;
    localparam logic [2:0] C_M_LOAD = 3'd1;
    localparam logic [2:0] C_M_SHL  = 3'd2;
    localparam logic [2:0] C_M_SHR  = 3'd3;
    localparam logic [2:0] C_M_ROTL = 3'd4;
    localparam logic [2:0] C_M_ROTR = 3'd5;
    localparam logic [2:0] C_M_ASR  = 3'd6;
    localparam logic [2:0] C_M_CLR  = 3'd7;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [2:0]       mode_q,  mode_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             w_mode_is_shift;
    logic             w_start_burst;
    logic             w_start_empty;
    logic             w_burst_last;

    // One-cycle transform of the register for a given mode.
    function automatic logic [WIDTH-1:0] f_apply(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (m)
            C_M_HOLD: r = cur;
            C_M_LOAD: r = ld;
            C_M_SHL:  r = {cur[WIDTH-2:0], sr};
            C_M_SHR:  r = {sl, cur[WIDTH-1:1]};
            C_M_ROTL: r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            C_M_ROTR: r = {cur[0], cur[WIDTH-1:1]};
            C_M_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            C_M_CLR:  r = {WIDTH{1'b0}};
            default:  r = cur;
        endcase
        return r;
    endfunction

    assign w_mode_is_shift = (mode >= C_M_SHL) && (mode <= C_M_ASR);
    assign w_start_burst   = start && w_mode_is_shift && (cnt != '0);
    assign w_start_empty   = start && (cnt == '0);
    assign w_burst_last    = (rem_q == CNT_W'(1));

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            data_q  <= RST_VAL;
            rem_q   <= '0;
            mode_q  <= C_M_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_burst) begin
                    state_d = S_SHIFT;
                    rem_d   = cnt;
                    mode_d  = mode;
                end else if (w_start_empty) begin
                    state_d = S_IDLE;
                end else if (en) begin
                    data_d  = f_apply(mode, data_q, d, ser_in_l, ser_in_r);
                end
            end
            S_SHIFT: begin
                data_d = f_apply(mode_q, data_q, d, ser_in_l, ser_in_r);
                rem_d  = rem_q - CNT_W'(1);
                if (w_burst_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered status outputs
    always_comb begin
        busy_d = (state_d == S_SHIFT);
        done_d = 1'b0;
        case (state_q)
            S_IDLE:  done_d = w_start_empty && !w_start_burst;
            S_SHIFT: done_d = w_burst_last;
            default: done_d = 1'b0;
        endcase
    end

    assign q         = data_q;
    assign ser_out_l = data_q[WIDTH-1];
    assign ser_out_r = data_q[0];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_univ
// Purpose  : Directed and randomized self-checking bench for shift_reg_univ.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_univ;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sl, sr;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic             sol, sor, busy, done;

    int total = 0;
    int bad   = 0;

    shift_reg_univ #(.WIDTH(WIDTH)) u_dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .ser_in_l  (sl),
        .ser_in_r  (sr),
        .start     (start),
        .cnt       (cnt),
        .q         (q),
        .ser_out_l (sol),
        .ser_out_r (sor),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dd,
                         input logic s, input logic [3:0] c);
        en = e; mode = m; d = dd; start = s; cnt = c;
    endtask

    // Reference: arithmetic description of each mode on an 8-bit value.
    function automatic int model_op(input int m, input int cur, input int ld, input int il, input int ir);
        case (m)
            0: return cur;
            1: return ld;
            2: return ((cur * 2) % 256) + ir;
            3: return (cur / 2) + il * 128;
            4: return ((cur * 2) % 256) + (cur / 128);
            5: return (cur / 2) + (cur % 2) * 128;
            6: return (cur / 2) + (cur >= 128 ? 128 : 0);
            default: return 0;
        endcase
    endfunction

    task automatic chk_state(input string tag, input int eq, input int eb, input int ed);
        chk({tag, ".q"},    32'(q),    32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    int mq;
    int ml;
    int n;
    int seen_done;

    initial begin
        rst = 1'b1; sl = 1'b0; sr = 1'b0;
        drive(1'b1, 3'd1, 8'hA5, 1'b0, 4'd0);
        tick(); tick();
        chk_state("reset", 'h00, 0, 0);
        rst = 1'b0;
        tick();
        chk("load_a5", 32'(q), 32'hA5);

        // Single operations
        drive(1'b1, 3'd2, 8'h00, 1'b0, 4'd0); sr = 1'b1; tick(); chk("shl", 32'(q), 32'h4B);
        drive(1'b1, 3'd3, 8'h00, 1'b0, 4'd0); sl = 1'b0; tick(); chk("shr", 32'(q), 32'h25);
        drive(1'b1, 3'd4, 8'h00, 1'b0, 4'd0); tick(); chk("rotl", 32'(q), 32'h4A);
        drive(1'b1, 3'd1, 8'h96, 1'b0, 4'd0); tick(); chk("load_96", 32'(q), 32'h96);
        chk("sol_96", 32'(sol), 32'd1);
        chk("sor_96", 32'(sor), 32'd0);
        drive(1'b1, 3'd6, 8'h00, 1'b0, 4'd0); tick(); chk("asr", 32'(q), 32'hCB);
        drive(1'b1, 3'd5, 8'h00, 1'b0, 4'd0); tick(); chk("rotr", 32'(q), 32'hE5);
        chk("sor_e5", 32'(sor), 32'd1);
        drive(1'b1, 3'd7, 8'h00, 1'b0, 4'd0); tick(); chk("clr", 32'(q), 32'h00);
        drive(1'b1, 3'd1, 8'h3C, 1'b0, 4'd0); tick();
        drive(1'b0, 3'd1, 8'hFF, 1'b0, 4'd0); tick(); chk("en0_hold", 32'(q), 32'h3C);

        // Burst ROTL x3 on 0x81
        drive(1'b1, 3'd1, 8'h81, 1'b0, 4'd0); tick();
        drive(1'b0, 3'd4, 8'h00, 1'b1, 4'd3); tick(); chk_state("b_e0", 'h81, 1, 0);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 4'd0);
        tick(); chk_state("b_e1", 'h03, 1, 0);
        tick(); chk_state("b_e2", 'h06, 1, 0);
        tick(); chk_state("b_e3", 'h0C, 0, 1);
        tick(); chk_state("b_e4", 'h0C, 0, 0);

        // Busy protection: SHR x4 on 0xF0 with hostile controls
        drive(1'b1, 3'd1, 8'hF0, 1'b0, 4'd0); tick();
        sl = 1'b0;
        drive(1'b0, 3'd3, 8'h00, 1'b1, 4'd4); tick();
        drive(1'b1, 3'd1, 8'hFF, 1'b1, 4'd4);
        seen_done = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        chk("prot_q", 32'(q), 32'h0F);
        chk("prot_done_end", 32'(done), 32'd1);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 4'd0); tick();
        chk("prot_done_cnt", 32'(seen_done), 32'd1);
        chk_state("prot_after", 'h0F, 0, 0);

        // Reset mid-burst
        drive(1'b1, 3'd1, 8'h01, 1'b0, 4'd0); tick();
        drive(1'b0, 3'd4, 8'h00, 1'b1, 4'd5); tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 4'd0);
        tick(); tick(); chk("mid_q2", 32'(q), 32'h04);
        rst = 1'b1; tick(); chk_state("mid_rst", 'h00, 0, 0);
        rst = 1'b0; tick(); chk_state("mid_after", 'h00, 0, 0);
        tick(); chk_state("mid_after2", 'h00, 0, 0);

        // cnt=0 start
        drive(1'b1, 3'd1, 8'h5A, 1'b0, 4'd0); tick();
        drive(1'b1, 3'd2, 8'h00, 1'b1, 4'd0); tick(); chk_state("cnt0", 'h5A, 0, 1);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 4'd0); tick(); chk_state("cnt0_after", 'h5A, 0, 0);

        // ASR x9 on 0x80 (cnt beyond WIDTH)
        drive(1'b1, 3'd1, 8'h80, 1'b0, 4'd0); tick();
        drive(1'b0, 3'd6, 8'h00, 1'b1, 4'd9); tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 4'd0);
        for (int k = 1; k <= 8; k++) tick();
        chk_state("asr9_e8", 'hFF, 1, 0);
        tick(); chk_state("asr9_e9", 'hFF, 0, 1);
        tick(); chk_state("asr9_after", 'hFF, 0, 0);

        // Randomized phase against the reference model
        mq = 'hFF;
        for (int it = 0; it < 400; it++) begin
            en    = 1'($urandom);
            mode  = 3'($urandom);
            d     = 8'($urandom);
            sl    = 1'($urandom);
            sr    = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
            cnt   = 4'($urandom_range(0, 12));
            rst   = ($urandom_range(0, 49) == 0);
            if (rst) begin
                mq = 0;
                tick();
                chk_state("rnd_rst", mq, 0, 0);
                rst = 1'b0;
            end else if (start && mode >= 2 && mode <= 6 && cnt != 0) begin
                ml = int'(mode);
                n  = int'(cnt);
                tick();
                chk_state("rnd_b0", mq, 1, 0);
                for (int k = 1; k <= n; k++) begin
                    en    = 1'($urandom);
                    mode  = 3'($urandom);
                    d     = 8'($urandom);
                    start = 1'($urandom);
                    cnt   = 4'($urandom);
                    sl    = 1'($urandom);
                    sr    = 1'($urandom);
                    mq = model_op(ml, mq, 0, int'(sl), int'(sr));
                    tick();
                    chk_state("rnd_bk", mq, (k != n) ? 1 : 0, (k == n) ? 1 : 0);
                end
            end else if (start && cnt == 0) begin
                tick();
                chk_state("rnd_cnt0", mq, 0, 1);
            end else begin
                if (en) mq = model_op(int'(mode), mq, int'(d), int'(sl), int'(sr));
                tick();
                chk_state("rnd_op", mq, 0, 0);
                chk("rnd_sol", 32'(sol), 32'(mq / 128));
                chk("rnd_sor", 32'(sor), 32'(mq % 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
